// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Holds one instruction from execute and waits for the data-SRAM
// response on loads. Aligns and extends the load data and hands
// {pc, rf_we, rf_addr, rf_wdata} to writeback. A one-entry buffer keeps
// a load word that returns while writeback is stalled, because the SRAM
// presents each response for one cycle only.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [73:0] es_to_ms_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [38:0] ms_to_ds_bus
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  // Pipeline registers.
  logic        ms_valid_q, ms_valid_d;
  logic [73:0] bus_q, bus_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;

  // Fields of the latched execute bus.
  logic [31:0] pc;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic        res_from_mem;
  logic [2:0]  load_type;
  logic [31:0] alu_result;

  assign pc           = bus_q[73:42];
  assign rf_we        = bus_q[41];
  assign rf_addr      = bus_q[40:36];
  assign res_from_mem = bus_q[35];
  assign load_type    = bus_q[34:32];
  assign alu_result   = bus_q[31:0];

  logic        ms_ready_go;
  logic        retire;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  // A load is done once its word is here, either live from the SRAM or
  // already parked in the buffer; non-loads are done immediately.
  assign ms_ready_go    = !res_from_mem || data_sram_data_ok || buf_valid_q;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign retire         = ms_to_ws_valid && ws_allowin;

  // Once buffered, the SRAM data lines are no longer meaningful.
  assign load_word = buf_valid_q ? buf_data_q : data_sram_rdata;

  // Pick the addressed byte/halfword (little-endian) and extend it.
  always_comb begin
    load_byte = load_word[7:0];
    load_half = load_word[15:0];
    case (alu_result[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    if (alu_result[1]) begin
      load_half = load_word[31:16];
    end
    case (load_type)
      LT_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      LT_LBU:  load_data = {24'd0, load_byte};
      LT_LH:   load_data = {{16{load_half[15]}}, load_half};
      LT_LHU:  load_data = {16'd0, load_half};
      LT_LW:   load_data = load_word;
      default: load_data = load_word;
    endcase
  end

  assign rf_wdata = res_from_mem ? load_data : alu_result;

  assign ms_to_ws_bus = {pc, rf_we, rf_addr, rf_wdata};

  // Decode stalls on a matching address while load_pending is high,
  // since fwd_data is not yet the real load value then.
  assign ms_to_ds_bus = {ms_valid_q && rf_we,
                         rf_addr,
                         rf_wdata,
                         ms_valid_q && res_from_mem && !ms_ready_go};

  // Next-state: stage occupancy, bus capture and the response buffer.
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;

    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (ms_allowin && es_to_ms_valid) begin
      bus_d = es_to_ms_bus;
    end

    // A response that arrives while writeback is blocked would be lost
    // after this cycle, so park it until the instruction retires.
    if (retire) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && res_from_mem && data_sram_data_ok &&
                 !buf_valid_q && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. The stimulus side plays
// execute, the data SRAM and writeback; each accepted instruction pushes
// its expected writeback bus (computed from the ISA load rules) into a
// queue, and an independent monitor checks every presented result.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [69:0] exp_q[$];

  // Driver state: next instruction from execute, and the load the SRAM owes.
  logic [73:0] nxt_bus   = '0;
  logic [31:0] nxt_rdata = '0;
  int          nxt_delay = 0;
  bit          nxt_valid = 0;
  bit          ld_wait   = 0;
  int          ld_cnt    = 0;
  logic [31:0] ld_rdata  = '0;
  bit          ws_force  = 1;
  bit          ws_val    = 1;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] ra,
                                     input logic ld, input logic [2:0] lt, input logic [31:0] alu);
    return {pc, we, ra, ld, lt, alu};
  endfunction

  // Reference: what writeback must receive for an instruction, given the
  // word the SRAM will return for it.
  function automatic logic [69:0] model(input logic [73:0] b, input logic [31:0] rd);
    logic [31:0] addr, w, v;
    int unsigned off;
    addr = b[31:0];
    off  = addr % 4;
    w    = addr;
    if (b[35]) begin
      case (b[34:32])
        3'd1: begin v = (rd >> (8 * off)) & 32'hFF;          w = (v >= 128)   ? v - 256   : v; end
        3'd2: w = (rd >> (8 * off)) & 32'hFF;
        3'd3: begin v = (rd >> (16 * (off / 2))) & 32'hFFFF; w = (v >= 32768) ? v - 65536 : v; end
        3'd4: w = (rd >> (16 * (off / 2))) & 32'hFFFF;
        default: w = rd;
      endcase
    end
    return {b[73:42], b[41], b[40:36], w};
  endfunction

  function automatic logic [73:0] rand_bus();
    logic [2:0]  lt;
    logic [31:0] addr;
    logic        ld;
    lt   = 3'($urandom_range(0, 4));
    addr = $urandom;
    ld   = 1'($urandom_range(0, 1));
    if (ld && lt == 3'd0) addr[1:0] = 2'b00;
    if (ld && (lt == 3'd3 || lt == 3'd4)) addr[0] = 1'b0;
    return mk($urandom & 32'hFFFF_FFFC, 1'($urandom), 5'($urandom), ld, lt, addr);
  endfunction

  // One clock: drive inputs just after the edge, observe at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    data_sram_data_ok = ld_wait && (ld_cnt == 0);
    data_sram_rdata   = data_sram_data_ok ? ld_rdata : $urandom;
    ws_allowin        = ws_force ? ws_val : ($urandom_range(0, 9) < 7);
    es_to_ms_valid    = nxt_valid;
    es_to_ms_bus      = nxt_bus;
    @(negedge clk);
    if (data_sram_data_ok) ld_wait = 0;
    else if (ld_wait && ld_cnt > 0) ld_cnt--;
    if (!reset && ms_allowin && es_to_ms_valid) begin
      exp_q.push_back(model(es_to_ms_bus, nxt_rdata));
      ld_wait   = es_to_ms_bus[35];
      ld_cnt    = nxt_delay;
      ld_rdata  = nxt_rdata;
      nxt_valid = 0;
    end
  endtask

  // Present an instruction until the stage accepts it (bounded).
  task automatic issue(input logic [73:0] b, input logic [31:0] rd, input int dly);
    nxt_bus   = b;
    nxt_rdata = rd;
    nxt_delay = dly;
    nxt_valid = 1;
    for (int i = 0; i < 100 && nxt_valid; i++) cycle();
    if (nxt_valid) begin
      vectors++;
      errors++;
      $display("FAIL issue_timeout: got not accepted expected accepted within 100 cycles");
      nxt_valid = 0;
    end
  endtask

  // Monitor: whatever is presented must match the head of the scoreboard;
  // the head is consumed only when writeback takes it.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no valid output", ms_to_ws_bus);
      end else begin
        chk("ws_bus", ms_to_ws_bus, exp_q[0]);
        if (ws_allowin) begin
          $display("retire pc=%h we=%b addr=%0d wdata=%h", ms_to_ws_bus[69:38],
                   ms_to_ws_bus[37], ms_to_ws_bus[36:32], ms_to_ws_bus[31:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_a;
    reset             = 1'b1;
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk(32'h1234_5678, 1'b1, 5'd7, 1'b0, 3'd0, 32'hCAFE_F00D);
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    ws_allowin        = 1'b1;

    // Reset held two cycles while execute offers an instruction.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ws_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rst_allowin",  70'(ms_allowin),     70'd1);
    chk("rst_ws_bus",   ms_to_ws_bus,        70'd0);
    chk("rst_ds_bus",   70'(ms_to_ds_bus),   70'd0);
    es_to_ms_valid = 1'b0;
    reset          = 1'b0;

    // Back-to-back non-loads reach writeback in consecutive cycles.
    ws_force = 1; ws_val = 1;
    issue(mk(32'hBFC0_0000, 1'b1, 5'd3, 1'b0, 3'd0, 32'h5), 32'h0, 0);
    issue(mk(32'hBFC0_0004, 1'b1, 5'd4, 1'b0, 3'd0, 32'h7), 32'h0, 0);
    chk("b2b_first_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("b2b_first_pc",    70'(ms_to_ws_bus[69:38]), 70'(32'hBFC0_0000));
    cycle();
    chk("b2b_second_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("b2b_second_pc",    70'(ms_to_ws_bus[69:38]), 70'(32'hBFC0_0004));

    // LB / LBU from byte 3, response two cycles after entry.
    for (int k = 0; k < 2; k++) begin
      issue(mk(32'hBFC0_0010, 1'b1, 5'd5, 1'b1, (k == 0) ? 3'd1 : 3'd2, 32'h1000_0003),
            32'h80FF_1234, 2);
      cycle();
      chk("lb_pending_c0", 70'(ms_to_ds_bus[0]), 70'd1);
      cycle();
      chk("lb_pending_c1", 70'(ms_to_ds_bus[0]), 70'd1);
      cycle();
      chk("lb_pending_done", 70'(ms_to_ds_bus[0]), 70'd0);
      chk("lb_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("lb_wdata", 70'(ms_to_ws_bus[31:0]), (k == 0) ? 70'(32'hFFFF_FF80) : 70'(32'h0000_0080));
    end

    // LHU / LH from the upper halfword.
    for (int k = 0; k < 2; k++) begin
      issue(mk(32'hBFC0_0020, 1'b1, 5'd6, 1'b1, (k == 0) ? 3'd4 : 3'd3, 32'h2000_0002),
            32'h8001_ABCD, 1);
      cycle();
      cycle();
      chk("lh_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("lh_wdata", 70'(ms_to_ws_bus[31:0]), (k == 0) ? 70'(32'h0000_8001) : 70'(32'hFFFF_8001));
    end
    cycle();

    // Early data: LW word returns while writeback is stalled for 3 cycles.
    ws_val = 0;
    issue(mk(32'hBFC0_0030, 1'b1, 5'd8, 1'b1, 3'd0, 32'h3000_0000), 32'hDEAD_BEEF, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("early_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("early_wdata", 70'(ms_to_ws_bus[31:0]), 70'(32'hDEAD_BEEF));
    end
    ws_val = 1;
    cycle();
    chk("early_retire_valid", 70'(ms_to_ws_valid), 70'd1);
    // A following load must wait for its own response, not the old buffer.
    issue(mk(32'hBFC0_0034, 1'b1, 5'd9, 1'b1, 3'd0, 32'h3000_0004), 32'h0BAD_F00D, 1);
    cycle();
    chk("after_buf_pending", 70'(ms_to_ds_bus[0]), 70'd1);
    chk("after_buf_valid",   70'(ms_to_ws_valid),  70'd0);
    cycle();
    chk("after_buf_wdata", 70'(ms_to_ws_bus[31:0]), 70'(32'h0BAD_F00D));

    // Randomized traffic with random gaps, latencies and back-pressure.
    ws_force = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) cycle();
      issue(rand_bus(), $urandom, int'($urandom_range(0, 3)));
    end
    ws_force = 1; ws_val = 1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle();
    chk("drain_empty", 70'(exp_q.size()), 70'd0);

    // Reset while a load waits, then a stray response afterwards.
    pc_a = 32'hBFC0_0040;
    issue(mk(pc_a, 1'b1, 5'd10, 1'b1, 3'd0, 32'h4000_0000), 32'h1111_2222, 6);
    cycle();
    chk("midload_pending", 70'(ms_to_ds_bus[0]), 70'd1);
    reset   = 1'b1;
    ld_wait = 0;
    cycle();
    cycle();
    reset = 1'b0;
    exp_q.delete();
    ld_wait  = 1;
    ld_cnt   = 0;
    ld_rdata = 32'h3333_4444;
    cycle();
    chk("spurious_valid",   70'(ms_to_ws_valid), 70'd0);
    chk("spurious_allowin", 70'(ms_allowin),     70'd1);
    cycle();
    chk("spurious_after_valid", 70'(ms_to_ws_valid),  70'd0);
    chk("spurious_after_ds",    70'(ms_to_ds_bus[0]), 70'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS core, between the execute stage and `wb_stage`. Accepts one instruction at a time from execute and waits for the data-SRAM response on loads. Aligns and extends load data, then delivers `{pc, rf_we, rf_addr, rf_wdata}` to writeback over the valid/allowin handshake. Exports a forwarding/stall bus to decode, and holds an early-returned load word in a one-entry buffer while writeback back-pressures.

## Interface
- No parameters. Bus widths come from `cpu.vh`: `ES_TO_MS_BUS_WD` = 74, `MS_TO_WS_BUS_WD` = 70, `MS_TO_DS_BUS_WD` = 39.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `ms_allowin`  out  1  stage can accept from execute this cycle.
- `es_to_ms_valid`  in  1  execute presents an instruction.
- `es_to_ms_bus`  in  74  fields, MSB first:
  - `pc`[31:0]
  - `rf_we`
  - `rf_addr`[4:0]
  - `res_from_mem`: 1 = load whose request execute already issued.
  - `load_type`[2:0]: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
  - `alu_result`[31:0]: address for loads, result otherwise.
- `data_sram_data_ok`  in  1  load response valid.
- `data_sram_rdata`  in  32  load response word.
- `ws_allowin`  in  1  writeback can accept.
- `ms_to_ws_valid`  out  1  result valid to writeback.
- `ms_to_ws_bus`  out  70  `{pc[31:0], rf_we, rf_addr[4:0], rf_wdata[31:0]}`.
- `ms_to_ds_bus`  out  39  `{fwd_we, fwd_addr[4:0], fwd_data[31:0], load_pending}`.

## Operation
- `ms_valid` register:
  - reset → 0.
  - when `ms_allowin`, loads `es_to_ms_valid`.
- Bus register:
  - reset → 0.
  - loads `es_to_ms_bus` when `ms_allowin && es_to_ms_valid`.
- `ms_ready_go = !res_from_mem || data_sram_data_ok || buf_valid`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go`.
- Load word source:
  - `buf_valid` = 1 → `buf_data`.
  - otherwise → `data_sram_rdata`.
- Alignment (little-endian, `a = alu_result[1:0]`):
  - LW: whole word.
  - LB/LBU: byte `a`, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword `a[1]`, sign- or zero-extended.
  - Misaligned addresses never reach this stage; execute traps them.
- `rf_wdata`: aligned load data when `res_from_mem`, else `alu_result`.
- Response buffer:
  - Captures `data_sram_rdata` and sets `buf_valid` when `ms_valid && res_from_mem && data_sram_data_ok && !buf_valid && !ws_allowin`.
  - Clears when `ms_to_ws_valid && ws_allowin`.
  - Reset → `buf_valid` = 0, `buf_data` = 0.
- `data_sram_data_ok` is ignored when no load is waiting (`!ms_valid`, `!res_from_mem`, or `buf_valid`). The protocol guarantees exactly one response per issued load.
- Forwarding bus to decode:
  - `fwd_we = ms_valid && rf_we`.
  - `fwd_addr = rf_addr`.
  - `fwd_data = rf_wdata`.
  - `load_pending = ms_valid && res_from_mem && !ms_ready_go`. Decode stalls on an address match while this is 1.

## Timing
- Reset values: `ms_valid`=0, `ms_to_ws_valid`=0, `ms_allowin`=1, `ms_to_ws_bus`=0, `ms_to_ds_bus`=0.
- Non-load:
  - Enters at edge N.
  - `ms_to_ws_valid`=1 throughout cycle N.
  - Leaves at edge N+1 if `ws_allowin`.
- Load:
  - `ms_to_ws_valid` rises combinationally in the cycle `data_sram_data_ok`=1, which may be the first cycle in the stage.
  - Zero-cycle added latency when the response and `ws_allowin` coincide.
- Back-pressure:
  - Bus and `ms_to_ws_bus` stay stable while `ms_to_ws_valid && !ws_allowin`.
  - A buffered load word is held unchanged.
- Simultaneous retire and accept: when `ms_to_ws_valid && ws_allowin && es_to_ms_valid`, the new instruction replaces the old at the same edge. No bubble.
- Reset mid-load: `ms_valid` and `buf_valid` clear; any response arriving after reset is ignored.

## Test plan
- Reset held 2 cycles with `es_to_ms_valid`=1 → `ms_to_ws_valid`=0, `ms_allowin`=1, all bus outputs 0.
- Back-to-back non-loads: ADDU pc=0xBFC00000, r3, result 0x00000005, then pc=0xBFC00004, r4, 0x7, `ws_allowin`=1 → writeback sees them in consecutive cycles, no bubble.
- LB:
  - Setup: addr 0x...3, r5, `data_ok` 2 cycles after entry, rdata 0x80FF1234.
  - `load_pending`=1 for 2 cycles.
  - Then `rf_wdata`=0xFFFFFF80.
  - Same case with LBU gives 0x00000080.
- LHU/LH:
  - Setup: addr 0x...2, rdata 0x8001ABCD.
  - LHU gives 0x00008001.
  - LH gives 0xFFFF8001.
- Early data:
  - Stimulus: LW rdata 0xDEADBEEF returns while `ws_allowin`=0 for 3 cycles.
  - `buf_valid`=1 and `ms_to_ws_valid` held with `rf_wdata`=0xDEADBEEF.
  - Retire when `ws_allowin` rises; `buf_valid`=0 next cycle.
- Reset asserted while a load is waiting, then a spurious `data_ok` → no `ms_to_ws_valid` issued.
